// File: rtl/reset_pulse_responder.sv
// Receiving end of the injected-reset path: qualifies low pulses on inj_rst_n by
// length, replays the enable-register restore sequence over a valid/ready port
// after each qualified reset, and holds domain_rst until that replay finishes.
module reset_pulse_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_HOLD    = 200,
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] SF_EN_MASK  = 32'h1,
    parameter logic [31:0] CA_EN0_MASK = 32'hFFFF,
    parameter logic [31:0] MR_HNT_MASK = 32'h1,
    parameter logic [31:0] CA_EN3_MASK = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inj_rst_n,
    output logic             restore_valid,
    input  logic             restore_ready,
    output logic [1:0]       restore_idx,
    output logic [31:0]      restore_data,
    output logic             domain_rst,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [15:0]      evt_cnt,
    output logic             short_err,
    output logic             restore_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRestore,
        StDone
    } state_e;

    // Restore values indexed by register index; a zero entry is skipped.
    localparam logic [3:0][31:0] Masks = {CA_EN3_MASK, MR_HNT_MASK, CA_EN0_MASK, SF_EN_MASK};
    // Compare in a width that holds both the counter and MIN_HOLD without truncation.
    localparam int unsigned      CmpW       = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [CmpW-1:0]  MinHoldExt = CmpW'(MIN_HOLD);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [15:0]            evt_cnt_q, evt_cnt_d;
    logic                   short_err_q, short_err_d;

    logic                   s_n;
    logic [CmpW-1:0]        cnt_ext;
    logic                   first_found, next_found;
    logic [1:0]             first_idx, next_idx;

    assign s_n     = sync_q[SYNC_STAGES-1];
    assign cnt_ext = CmpW'(cnt_q);

    // Synchronizer chain; reset to the inactive (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inj_rst_n};
        end
    end

    // Find the first non-zero restore entry, and the next one after idx_q.
    always_comb begin
        first_found = 1'b0;
        first_idx   = 2'd0;
        next_found  = 1'b0;
        next_idx    = 2'd0;
        // Descending scan so the lowest matching index wins.
        for (int i = 3; i >= 0; i--) begin
            if (Masks[i] != 32'd0) begin
                first_found = 1'b1;
                first_idx   = 2'(i);
                if (i > int'(idx_q)) begin
                    next_found = 1'b1;
                    next_idx   = 2'(i);
                end
            end
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            hold_cnt_q  <= '0;
            evt_cnt_q   <= 16'd0;
            short_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            evt_cnt_q   <= evt_cnt_d;
            short_err_q <= short_err_d;
        end
    end

    // Next-state logic: measure the low window, qualify it, then replay.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        hold_cnt_d  = hold_cnt_q;
        evt_cnt_d   = evt_cnt_q;
        short_err_d = short_err_q;
        unique case (state_q)
            StIdle: begin
                if (!s_n) begin
                    state_d = StHold;
                    cnt_d   = CntOne;
                end
            end
            StHold: begin
                if (!s_n) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else if (cnt_ext < MinHoldExt) begin
                    short_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    hold_cnt_d = cnt_q;
                    evt_cnt_d  = evt_cnt_q + 16'd1;
                    idx_d      = first_idx;
                    state_d    = first_found ? StRestore : StDone;
                end
            end
            StRestore: begin
                // A new reset aborts the replay, even if the current beat is accepted.
                if (!s_n) begin
                    state_d = StHold;
                    cnt_d   = CntOne;
                end else if (restore_ready) begin
                    if (next_found) begin
                        idx_d = next_idx;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!s_n) begin
                    state_d = StHold;
                    cnt_d   = CntOne;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; index/data forced to zero outside a beat.
    always_comb begin
        restore_valid = (state_q == StRestore);
        restore_idx   = restore_valid ? idx_q : 2'd0;
        restore_data  = restore_valid ? Masks[idx_q] : 32'd0;
        domain_rst    = (state_q == StHold) || (state_q == StRestore);
        restore_done  = (state_q == StDone);
        busy          = (state_q != StIdle);
        hold_cnt      = hold_cnt_q;
        evt_cnt       = evt_cnt_q;
        short_err     = short_err_q;
    end

endmodule

// File: tb/tb_reset_pulse_responder.sv
// Self-checking bench for reset_pulse_responder: pulse qualification, restore
// replay with backpressure and abort, mid-hold reset, and counter saturation.
module tb_reset_pulse_responder;

    typedef logic [33:0] beat_t;

    logic        clk;
    logic        rst;
    logic        inj_rst_n;
    logic        restore_valid;
    logic        restore_ready;
    logic [1:0]  restore_idx;
    logic [31:0] restore_data;
    logic        domain_rst;
    logic [31:0] hold_cnt;
    logic [15:0] evt_cnt;
    logic        short_err;
    logic        restore_done;
    logic        busy;

    logic        inj2_n;
    logic        restore_valid2;
    logic        restore_ready2;
    logic [1:0]  restore_idx2;
    logic [31:0] restore_data2;
    logic        domain_rst2;
    logic [7:0]  hold_cnt2;
    logic [15:0] evt_cnt2;
    logic        short_err2;
    logic        restore_done2;
    logic        busy2;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t exp2_q[$];
    beat_t obs2_q[$];

    reset_pulse_responder dut (
        .clk           (clk),
        .rst           (rst),
        .inj_rst_n     (inj_rst_n),
        .restore_valid (restore_valid),
        .restore_ready (restore_ready),
        .restore_idx   (restore_idx),
        .restore_data  (restore_data),
        .domain_rst    (domain_rst),
        .hold_cnt      (hold_cnt),
        .evt_cnt       (evt_cnt),
        .short_err     (short_err),
        .restore_done  (restore_done),
        .busy          (busy)
    );

    reset_pulse_responder #(
        .CNT_W       (8),
        .CA_EN3_MASK (32'h3)
    ) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .inj_rst_n     (inj2_n),
        .restore_valid (restore_valid2),
        .restore_ready (restore_ready2),
        .restore_idx   (restore_idx2),
        .restore_data  (restore_data2),
        .domain_rst    (domain_rst2),
        .hold_cnt      (hold_cnt2),
        .evt_cnt       (evt_cnt2),
        .short_err     (short_err2),
        .restore_done  (restore_done2),
        .busy          (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepted beats just after the negedge, once the bench has driven ready.
    always @(negedge clk) begin
        #1;
        if (restore_valid && restore_ready) obs_q.push_back({restore_idx, restore_data});
        if (restore_valid2 && restore_ready2) obs2_q.push_back({restore_idx2, restore_data2});
    end

    task automatic test_reset();
        rst            = 1'b1;
        inj_rst_n      = 1'b1;
        inj2_n         = 1'b1;
        restore_ready  = 1'b1;
        restore_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({domain_rst, busy, restore_valid, restore_done, short_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got dr=%b busy=%b v=%b done=%b se=%b, want all 0",
                     domain_rst, busy, restore_valid, restore_done, short_err);
        end
        checks++;
        if ({hold_cnt, evt_cnt, restore_idx, restore_data} !== 82'd0) begin
            errors++;
            $display("FAIL reset_values: got hold=%0d evt=%0d idx=%0d data=0x%0h, want 0",
                     hold_cnt, evt_cnt, restore_idx, restore_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_short_pulse();
        int dr_cycles = 0;
        int v_cycles  = 0;
        inj_rst_n = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (domain_rst) dr_cycles++;
            if (restore_valid) v_cycles++;
            if (k == 49) inj_rst_n = 1'b1;
        end
        checks++;
        if (dr_cycles != 50) begin
            errors++;
            $display("FAIL short_domain_rst: got %0d high cycles, want 50", dr_cycles);
        end
        checks++;
        if (v_cycles != 0) begin
            errors++;
            $display("FAIL short_no_beats: got %0d valid cycles, want 0", v_cycles);
        end
        checks++;
        if ({short_err, evt_cnt, busy} !== {1'b1, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL short_status: got se=%b evt=%0d busy=%b, want se=1 evt=0 busy=0",
                     short_err, evt_cnt, busy);
        end
    endtask

    task automatic test_valid_pulse();
        bit    seen = 0;
        beat_t e, o;
        exp_q.push_back({2'd0, 32'h1});
        exp_q.push_back({2'd1, 32'hFFFF});
        exp_q.push_back({2'd2, 32'h1});
        restore_ready = 1'b1;
        inj_rst_n     = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if ({domain_rst, busy} !== 2'b11) begin
            errors++;
            $display("FAIL valid_hold: got dr=%b busy=%b, want 1 1", domain_rst, busy);
        end
        inj_rst_n = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (restore_done) begin
                seen = 1;
                checks++;
                if (domain_rst !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_done_dr: got dr=%b, want 0", domain_rst);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL valid_done: got no restore_done in 50 cycles, want pulse");
        end
        checks++;
        if ({hold_cnt, evt_cnt} !== {32'd200, 16'd1}) begin
            errors++;
            $display("FAIL valid_counts: got hold=%0d evt=%0d, want 200 1", hold_cnt, evt_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, domain_rst, restore_done} !== 3'b0) begin
            errors++;
            $display("FAIL valid_idle: got busy=%b dr=%b done=%b, want 0 0 0",
                     busy, domain_rst, restore_done);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL valid_beat: got none, want idx=%0d data=0x%0h", e[33:32], e[31:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL valid_beat: got idx=%0d data=0x%0h, want idx=%0d data=0x%0h",
                             o[33:32], o[31:0], e[33:32], e[31:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL valid_extra: got %0d extra beats, want 0", obs_q.size());
        end
        while (obs_q.size() > 0) o = obs_q.pop_front();
    endtask

    task automatic test_backpressure();
        bit    seen  = 0;
        int    stall = 0;
        beat_t e, o;
        exp_q.push_back({2'd0, 32'h1});
        exp_q.push_back({2'd1, 32'hFFFF});
        exp_q.push_back({2'd2, 32'h1});
        restore_ready = 1'b1;
        inj_rst_n     = 1'b0;
        repeat (300) @(negedge clk);
        inj_rst_n = 1'b1;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (restore_done) seen = 1;
            if (stall > 0 && stall < 5) begin
                checks++;
                if ({restore_valid, restore_idx, restore_data} !== {1'b1, 2'd1, 32'hFFFF}) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b idx=%0d data=0x%0h, want 1 1 0xffff",
                             restore_valid, restore_idx, restore_data);
                end
                stall++;
                restore_ready = 1'b0;
            end else if (stall == 0 && restore_valid && restore_idx == 2'd1) begin
                stall         = 1;
                restore_ready = 1'b0;
            end else begin
                restore_ready = 1'b1;
            end
        end
        restore_ready = 1'b1;
        checks++;
        if (!seen || stall != 5) begin
            errors++;
            $display("FAIL bp_done: got done=%b stall=%0d, want done=1 stall=5", seen, stall);
        end
        checks++;
        if ({hold_cnt, evt_cnt} !== {32'd300, 16'd2}) begin
            errors++;
            $display("FAIL bp_counts: got hold=%0d evt=%0d, want 300 2", hold_cnt, evt_cnt);
        end
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL bp_beat: got none, want idx=%0d data=0x%0h", e[33:32], e[31:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL bp_beat: got idx=%0d data=0x%0h, want idx=%0d data=0x%0h",
                             o[33:32], o[31:0], e[33:32], e[31:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bp_extra: got %0d extra beats, want 0", obs_q.size());
        end
        while (obs_q.size() > 0) o = obs_q.pop_front();
    endtask

    task automatic test_abort();
        bit    hit  = 0;
        bit    seen = 0;
        beat_t e, o;
        // Only idx0 is accepted before the abort lands.
        exp_q.push_back({2'd0, 32'h1});
        restore_ready = 1'b1;
        inj_rst_n     = 1'b0;
        repeat (200) @(negedge clk);
        inj_rst_n = 1'b1;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            if (restore_valid && restore_idx == 2'd1) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach_idx1: got no idx1 beat in 50 cycles, want one");
        end
        restore_ready = 1'b0;
        inj_rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({restore_valid, restore_idx} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL abort_pre: got v=%b idx=%0d, want v=1 idx=1", restore_valid, restore_idx);
        end
        @(negedge clk);
        checks++;
        if ({restore_valid, busy, domain_rst, evt_cnt} !== {3'b011, 16'd3}) begin
            errors++;
            $display("FAIL abort_drop: got v=%b busy=%b dr=%b evt=%0d, want 0 1 1 3",
                     restore_valid, busy, domain_rst, evt_cnt);
        end
        exp_q.push_back({2'd0, 32'h1});
        exp_q.push_back({2'd1, 32'hFFFF});
        exp_q.push_back({2'd2, 32'h1});
        restore_ready = 1'b1;
        repeat (247) @(negedge clk);
        inj_rst_n = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (restore_done) seen = 1;
        end
        checks++;
        if (!seen || {hold_cnt, evt_cnt} !== {32'd250, 16'd4}) begin
            errors++;
            $display("FAIL abort_replay: got done=%b hold=%0d evt=%0d, want 1 250 4",
                     seen, hold_cnt, evt_cnt);
        end
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL abort_beat: got none, want idx=%0d data=0x%0h", e[33:32], e[31:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_beat: got idx=%0d data=0x%0h, want idx=%0d data=0x%0h",
                             o[33:32], o[31:0], e[33:32], e[31:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_extra: got %0d extra beats, want 0", obs_q.size());
        end
        while (obs_q.size() > 0) o = obs_q.pop_front();
    endtask

    task automatic test_rst_mid_hold();
        int lat = 0;
        inj_rst_n = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (domain_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got dr=%b, want 1", domain_rst);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({domain_rst, busy, restore_valid, restore_done, short_err, hold_cnt, evt_cnt}
            !== 53'd0) begin
            errors++;
            $display("FAIL rst_clear: got dr=%b busy=%b v=%b done=%b se=%b hold=%0d evt=%0d, want 0",
                     domain_rst, busy, restore_valid, restore_done, short_err, hold_cnt, evt_cnt);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (domain_rst) lat = k;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL rst_relatch: got domain_rst after %0d cycles, want 3", lat);
        end
        inj_rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_saturation();
        bit    seen = 0;
        beat_t e, o;
        exp2_q.push_back({2'd0, 32'h1});
        exp2_q.push_back({2'd1, 32'hFFFF});
        exp2_q.push_back({2'd2, 32'h1});
        exp2_q.push_back({2'd3, 32'h3});
        restore_ready2 = 1'b1;
        inj2_n         = 1'b0;
        repeat (300) @(negedge clk);
        inj2_n = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (restore_done2) seen = 1;
        end
        checks++;
        if (!seen || {hold_cnt2, evt_cnt2} !== {8'hFF, 16'd1}) begin
            errors++;
            $display("FAIL sat_counts: got done=%b hold=%0d evt=%0d, want 1 255 1",
                     seen, hold_cnt2, evt_cnt2);
        end
        repeat (3) @(negedge clk);
        while (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            checks++;
            if (obs2_q.size() == 0) begin
                errors++;
                $display("FAIL sat_beat: got none, want idx=%0d data=0x%0h", e[33:32], e[31:0]);
            end else begin
                o = obs2_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL sat_beat: got idx=%0d data=0x%0h, want idx=%0d data=0x%0h",
                             o[33:32], o[31:0], e[33:32], e[31:0]);
                end
            end
        end
        checks++;
        if (obs2_q.size() != 0) begin
            errors++;
            $display("FAIL sat_extra: got %0d extra beats, want 0", obs2_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_valid_pulse();
        test_backpressure();
        test_abort();
        test_rst_mid_hold();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
